// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulsed-output command sequencer.
// Default widths here are the parameter defaults of pulse_sequencer.
package pulse_seq_pkg;

    localparam int DELAY_W   = 48;
    localparam int SHUTTER_W = 64;
    localparam int CNT_W     = 32;

    localparam int MIN_ENABLED_DELAY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ARM  = 2'd2,
        WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_sequencer.sv
// Issues pulse commands to the delay counter / output mux as load strobes.
// Define PULSE_SEQ_UNDERRUN_EN for sequence tracking and sticky underrun.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int DELAY_W   = pulse_seq_pkg::DELAY_W,
    parameter int SHUTTER_W = pulse_seq_pkg::SHUTTER_W,
    parameter int CNT_W     = pulse_seq_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [DELAY_W-1:0]   cmd_delay,
    input  logic [SHUTTER_W-1:0] cmd_shutter,
    input  logic [SHUTTER_W-1:0] cmd_end_shutter,
    input  logic                 cmd_pulse_mode,
    input  logic                 cmd_last,
    input  logic                 abort,
    input  logic                 wait_expired,
    output logic                 timed_delay_start,
    output logic [DELAY_W-1:0]   timed_delay,
    output logic [SHUTTER_W-1:0] shutter_buffer,
    output logic [SHUTTER_W-1:0] pulse_end_shutter,
    output logic                 pulse_mode,
    output logic                 wait_counter_rst,
    output logic                 busy,
    output logic                 underrun,
    output logic [CNT_W-1:0]     cmd_count
);

    state_t state;
    state_t state_nxt;
    logic   ready_en;
    logic   accept;
    logic   issue;
    logic   short_dly;
    logic   handoff;

    assign accept    = cmd_valid & cmd_ready;
    assign issue     = (state == LOAD) & !abort;
    assign short_dly = timed_delay < DELAY_W'(MIN_ENABLED_DELAY);
    assign handoff   = !abort &
                       (((state == LOAD) & short_dly) |
                        ((state == WAIT) & wait_expired));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ready_en          <= 1'b0;
            timed_delay       <= '0;
            shutter_buffer    <= '0;
            pulse_end_shutter <= '0;
            pulse_mode        <= 1'b0;
            wait_counter_rst  <= 1'b0;
            cmd_count         <= '0;
        end else begin
            state            <= state_nxt;
            ready_en         <= 1'b1;
            wait_counter_rst <= abort;
            if (accept) begin
                timed_delay       <= cmd_delay;
                shutter_buffer    <= cmd_shutter;
                pulse_end_shutter <= cmd_end_shutter;
                pulse_mode        <= cmd_pulse_mode;
            end
            if (issue)
                cmd_count <= cmd_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_nxt = LOAD;
                LOAD: begin
                    if (short_dly)
                        state_nxt = accept ? LOAD : IDLE;
                    else
                        state_nxt = ARM;
                end
                ARM:  state_nxt = WAIT;
                WAIT: begin
                    if (wait_expired)
                        state_nxt = accept ? LOAD : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Expiry is stale in ARM, so only LOAD(short) and WAIT may hand off.
    always_comb begin
        cmd_ready         = 1'b0;
        timed_delay_start = issue;
        busy              = (state != IDLE);
        unique case (state)
            IDLE:    cmd_ready = ready_en & !abort;
            LOAD:    cmd_ready = short_dly & !abort;
            WAIT:    cmd_ready = wait_expired & !abort;
            default: cmd_ready = 1'b0;
        endcase
    end

`ifdef PULSE_SEQ_UNDERRUN_EN
    logic seq_active;
    logic last_q;
    logic underrun_q;
    logic starved;

    assign starved = handoff & !cmd_valid & seq_active &
                     !((state == LOAD) & last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_active <= 1'b0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (accept)
                last_q <= cmd_last;
            if (abort)
                seq_active <= 1'b0;
            else if (accept)
                seq_active <= 1'b1;
            else if (issue & last_q)
                seq_active <= 1'b0;
            if (starved)
                underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`else
    logic unused_last;
    logic unused_handoff;

    assign unused_last    = cmd_last;
    assign unused_handoff = handoff;
    assign underrun       = 1'b0;
`endif

endmodule
